// File: rtl/intr_controller_pkg.sv
// Shared peripheral header: OCP bus widths and command/response codes,
// interrupt-controller register offsets and the ID valid-bit position.
package intr_controller_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int BEN_WIDTH  = DATA_WIDTH / 8;

   localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
   localparam logic [2:0] OCP_CMD_WRITE = 3'b001;
   localparam logic [2:0] OCP_CMD_READ  = 3'b010;

   localparam logic [1:0] OCP_RESP_NULL = 2'b00;
   localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
   localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

   // Word index of each register, taken from address bits [4:2]
   localparam logic [2:0] INTC_STATUS = 3'd0;
   localparam logic [2:0] INTC_PEND   = 3'd1;
   localparam logic [2:0] INTC_MASK   = 3'd2;
   localparam logic [2:0] INTC_ID     = 3'd3;
   localparam logic [2:0] INTC_TRIG   = 3'd4;

   localparam int INTC_ID_VALID_BIT = 31;

   function automatic logic [DATA_WIDTH-1:0] expand_ben(input logic [BEN_WIDTH-1:0] ben);
      logic [DATA_WIDTH-1:0] bits;
      bits = '0;
      for (int b = 0; b < BEN_WIDTH; b++) begin
         bits[b*8 +: 8] = {8{ben[b]}};
      end
      return bits;
   endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational priority encoder: reports whether any bit of vec is set and
// the index of the lowest set bit (index reads 0 when nothing is set).
module intc_prio_enc #(
   parameter int W = 8
) (
   input  logic [W-1:0] vec,
   output logic         valid,
   output logic [4:0]   idx
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec[i]) begin
            valid = 1'b1;
            idx   = 5'(i);
         end
      end
   end

endmodule

// File: rtl/intr_controller.sv
// Programmable interrupt controller behind a single-cycle OCP slave port.
// Optional feature macro: INTC_TRIGGER_SEL_EN (TRIG register, edge/level lines).
module intr_controller
   import intr_controller_pkg::*;
#(
   parameter int NR_LINES = 8
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [ADDR_WIDTH-1:0] i_MAddr,
   input  logic [2:0]            i_MCmd,
   input  logic [DATA_WIDTH-1:0] i_MData,
   input  logic [BEN_WIDTH-1:0]  i_MByteEn,
   output logic                  o_SCmdAccept,
   output logic [DATA_WIDTH-1:0] o_SData,
   output logic [1:0]            o_SResp,
   input  logic [NR_LINES-1:0]   i_irq,
   output logic                  o_intr
);

   // Bits at or above NR_LINES stay zero in every register.
   localparam logic [DATA_WIDTH-1:0] LINE_MASK = (DATA_WIDTH'(1) << NR_LINES) - DATA_WIDTH'(1);

   logic [DATA_WIDTH-1:0] pend_q, mask_q, status, id_word, rd_data;
   logic [DATA_WIDTH-1:0] wr_bits, w1c_vec, set_vec, irq_ext, pend_d;
   logic [2:0]            reg_idx;
   logic                  is_wr, is_rd, hit, mask_we;
   logic                  id_valid;
   logic [4:0]            id_idx;
   logic                  unused_addr;

   assign unused_addr = ^{i_MAddr[ADDR_WIDTH-1:5], i_MAddr[1:0]};

   // Bus contract: a command is valid whenever i_MCmd != IDLE and is always
   // accepted in that same cycle (no wait states); its response (DVA/ERR)
   // is presented for exactly one cycle on the following cycle, else NULL.
   assign o_SCmdAccept = (i_MCmd != OCP_CMD_IDLE);
   assign is_wr        = (i_MCmd == OCP_CMD_WRITE);
   assign is_rd        = (i_MCmd == OCP_CMD_READ);
   assign reg_idx      = i_MAddr[4:2];

   assign irq_ext = DATA_WIDTH'(i_irq);
   assign status  = pend_q & mask_q;

   intc_prio_enc #(.W(NR_LINES)) u_prio (
      .vec   (status[NR_LINES-1:0]),
      .valid (id_valid),
      .idx   (id_idx)
   );

   always_comb begin
      id_word                    = '0;
      id_word[INTC_ID_VALID_BIT] = id_valid;
      id_word[4:0]               = id_idx;
   end

`ifdef INTC_TRIGGER_SEL_EN
   logic [DATA_WIDTH-1:0] trig_q, prev_q;
   logic                  trig_we;
`endif

   always_comb begin
      hit     = 1'b1;
      rd_data = '0;
      case (reg_idx)
         INTC_STATUS: rd_data = status;
         INTC_PEND:   rd_data = pend_q;
         INTC_MASK:   rd_data = mask_q;
         INTC_ID:     rd_data = id_word;
         INTC_TRIG: begin
`ifdef INTC_TRIGGER_SEL_EN
            rd_data = trig_q;
`else
            hit = 1'b0;
`endif
         end
         default:     hit = 1'b0;
      endcase
   end

   assign wr_bits = expand_ben(i_MByteEn) & LINE_MASK;
   assign mask_we = is_wr && (reg_idx == INTC_MASK);
   assign w1c_vec = (is_wr && (reg_idx == INTC_PEND)) ? (i_MData & wr_bits) : '0;

`ifdef INTC_TRIGGER_SEL_EN
   // Edge lines only set on a rising input; level lines set while high.
   assign set_vec = irq_ext & ~(trig_q & prev_q);
   assign trig_we = is_wr && (reg_idx == INTC_TRIG);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         trig_q <= '0;
         prev_q <= '0;
      end else begin
         prev_q <= irq_ext;
         if (trig_we) trig_q <= (trig_q & ~wr_bits) | (i_MData & wr_bits);
      end
   end
`else
   assign set_vec = irq_ext;
`endif

   // A set event in the same cycle as a W1C wins.
   assign pend_d = (set_vec | (pend_q & ~w1c_vec)) & LINE_MASK;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pend_q  <= '0;
         mask_q  <= '0;
         o_intr  <= 1'b0;
         o_SData <= '0;
         o_SResp <= OCP_RESP_NULL;
      end else begin
         pend_q  <= pend_d;
         o_intr  <= |status;
         o_SData <= '0;
         o_SResp <= OCP_RESP_NULL;
         if (mask_we) mask_q <= (mask_q & ~wr_bits) | (i_MData & wr_bits);
         if (is_rd) begin
            o_SResp <= hit ? OCP_RESP_DVA : OCP_RESP_ERR;
            o_SData <= rd_data;
         end else if (is_wr) begin
            o_SResp <= hit ? OCP_RESP_DVA : OCP_RESP_ERR;
         end else if (o_SCmdAccept) begin
            o_SResp <= OCP_RESP_ERR;
         end
      end
   end

endmodule

// File: doc/intr_controller.md
# intr_controller

Programmable interrupt controller on the OCP peripheral bus, directly downstream of `interval_timer` and other peripherals. It collects up to `NR_LINES` peripheral interrupt lines (timer `o_intr` on line 0), latches them into a pending register, and applies a per-line mask. It drives a single registered interrupt request to the CPU and exposes the lowest-index active line as a vector ID. The block is a standard single-cycle OCP slave, with the same bus contract as the timer.

## Interface
- `NR_LINES`, default 8: number of interrupt inputs, legal range 1..32.
- `clk`  in  1: system clock; all logic on the rising edge.
- `nrst`  in  1: asynchronous, active-low reset.
- `i_MAddr`  in  `ADDR_WIDTH`: OCP address; bits [4:2] decoded.
- `i_MCmd`  in  3: OCP command (IDLE/WRITE/READ).
- `i_MData`  in  `DATA_WIDTH`: write data.
- `i_MByteEn`  in  `BEN_WIDTH`: byte enables for writes.
- `o_SCmdAccept`  out  1: command accept.
- `o_SData`  out  `DATA_WIDTH`: read data.
- `o_SResp`  out  2: OCP response (NULL/DVA/ERR).
- `i_irq`  in  `NR_LINES`: peripheral interrupt lines, synchronous to `clk`, active high.
- `o_intr`  out  1: interrupt request to CPU, registered.

## Operation
- Register map (word offsets):
  - 0x00 STATUS (RO) = PEND & MASK.
  - 0x04 PEND: read returns raw pending; write-1-to-clear.
  - 0x08 MASK (RW): 1 = line enabled.
  - 0x0C ID (RO): bit 31 = valid; bits [4:0] = lowest-index set bit of STATUS; reads 0 when no bit is set.
  - 0x10 TRIG (RW, only with macro): 1 = edge-triggered.
- Writes update only bytes whose `i_MByteEn` bit is 1. Register bits at or above `NR_LINES` read 0 and ignore writes.
- Level line: the PEND bit is set every cycle the input is high. A W1C write while the input is high has no lasting effect, because the bit re-sets the next cycle.
- Edge line: the PEND bit is set on a 0→1 transition of the input (a previous-value register holds the input from the last cycle). The bit holds until a W1C write.
- A set event and a W1C on the same line in the same cycle leave the bit set; the set wins.
- `o_intr` next cycle = |(PEND & MASK) as computed from the current cycle's register values.
- An unmapped offset (0x14–0x1C, or 0x10 without the macro) returns ERR. Reads of it return 0; writes to it are dropped.
- Reset clears everything: PEND=0, MASK=0, TRIG=0, previous-input register=0, `o_intr`=0, `o_SData`=0, `o_SResp`=NULL. A reset mid-transaction discards the transaction with no response.

## Timing
- `o_SCmdAccept` is combinational: 1 whenever `i_MCmd` ≠ IDLE. There are no wait states.
- Response comes in the cycle after the command. `o_SResp`=DVA (or ERR) for exactly one cycle, with `o_SData` valid in that cycle for reads. Otherwise `o_SResp`=NULL and `o_SData` holds 0.
- A write takes effect at the accepting clock edge, so a read issued in the next cycle returns the new value.
- Input-to-`o_intr` latency for an unmasked line:
  - Level line: input high in cycle N → PEND set at edge N+1 → `o_intr` high from edge N+2.
  - Edge line: same latency.
- After a W1C at edge N that removes the last active bit, `o_intr` deasserts at edge N+1.
- Back-to-back commands in consecutive cycles are supported. Each command gets its own response one cycle later.

## Configuration
- `INTC_TRIGGER_SEL_EN`
  - Defined: the TRIG register at 0x10 and per-line edge/level selection exist.
  - Undefined: every line is level-sensitive, no previous-input register is built, and 0x10 returns ERR.

## Structure
- The shared header with the other peripherals holds:
  - register offsets (`INTC_STATUS`, `INTC_PEND`, `INTC_MASK`, `INTC_ID`, `INTC_TRIG`);
  - the ID valid-bit position.
- OCP command and response codes come from the existing OCP constants header.
- One sub-module, `intc_prio_enc`, is parameterised by width. It takes STATUS and produces valid plus the 5-bit index, lowest index first. It is purely combinational.

## Test plan
- Reset → `o_intr`=0. Reading MASK/PEND/STATUS/ID returns 0x0, 0x0, 0x0, 0x0 with DVA one cycle after each READ.
- Write MASK=0x05, drive `i_irq`=0x04 level → PEND=0x04, STATUS=0x04, ID=0x80000002. `o_intr` rises two cycles after `i_irq`. Dropping `i_irq` and writing PEND=0x04 → `o_intr` falls the next cycle.
- `i_irq`=0x06 with MASK=0x02 → ID=0x80000001, STATUS=0x02. Set MASK=0x00 → `o_intr`=0 next cycle while PEND stays 0x06.
- (macro) Write TRIG=0x01, pulse `i_irq[0]` for one cycle → PEND[0] stays 1. A W1C in the same cycle as a new rising edge leaves PEND[0]=1.
- Write MASK=0xFFFFFFFF with MByteEn=0x1 → MASK reads 0xFF for `NR_LINES`=8. A READ at 0x1C → SResp=ERR, SData=0.
- Assert `nrst` low mid-READ → no response is issued, and all registers and `o_intr` read 0 after release.
